// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one uart_tx between NREQ
// byte producers. Each producer owns a one-byte holding slot; the scheduler
// picks a full slot, strobes it into uart_tx, and waits for tx_complete.
// It also owns the line configuration and applies it only between frames.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req_valid/req_data  per-requester byte offer (byte i at [8i+7:8i])
//   req_ready           slot i empty (combinational from slot-full register)
//   req_sent            one-cycle pulse when requester i's byte has finished
//   cfg_we, cfg_*       configuration write, deferred until the next idle
//   utx_*               connections to the uart_tx instance
//   busy                high while issuing or waiting for a frame
//   grant_id            index of the last granted requester
module uart_tx_sched #(
    parameter int          NREQ                 = 4,
    parameter logic [15:0] DEFAULT_BIT_DURATION = 16'd433,
    parameter logic [1:0]  DEFAULT_STOPBITS     = 2'b01
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [8*NREQ-1:0]       req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic [NREQ-1:0]         req_sent,
    input  logic                    cfg_we,
    input  logic [15:0]             cfg_bit_duration,
    input  logic [1:0]              cfg_stopbits,
    output logic [7:0]              utx_data,
    output logic                    utx_data_ready,
    output logic [15:0]             utx_bit_duration,
    output logic [1:0]              utx_stopbits,
    input  logic                    utx_tx_complete,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant_id
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t                 state_reg, state_next;
    logic [NREQ-1:0]        slot_full_reg, slot_full_next;
    logic [NREQ-1:0][7:0]   slot_data_reg, slot_data_next;
    logic [IW-1:0]          ptr_reg, ptr_next;
    logic [IW-1:0]          grant_reg, grant_next;
    logic [7:0]             utx_data_reg, utx_data_next;
    logic                   data_ready_reg, data_ready_next;
    logic [15:0]            bit_duration_reg, bit_duration_next;
    logic [1:0]             stopbits_reg, stopbits_next;
    logic                   cfg_pending_reg, cfg_pending_next;
    logic [15:0]            pend_bit_duration_reg;
    logic [1:0]             pend_stopbits_reg;
    logic [NREQ-1:0]        req_sent_reg, req_sent_next;
    logic                   busy_reg, busy_next;
    logic                   first_wait_reg, first_wait_next;
    logic                   pend_clear;

    // Candidate order for the round-robin search: cand_idx[k] is
    // (ptr + k + 1) mod NREQ, so scanning k upward starts just after the
    // last grant.
    logic [IW-1:0]          cand_idx [NREQ];
    logic [NREQ-1:0]        cand_full;
    logic                   pick_valid;
    logic [IW-1:0]          pick_idx;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slot
            assign cand_idx[gi]  = (ptr_reg >= IW'(NREQ - 1 - gi))
                                 ? ptr_reg - IW'(NREQ - 1 - gi)
                                 : ptr_reg + IW'(gi + 1);
            assign cand_full[gi] = slot_full_reg[cand_idx[gi]];
            // A byte is only captured into an empty slot.
            assign slot_data_next[gi] = (req_valid[gi] && !slot_full_reg[gi])
                                      ? req_data[8*gi +: 8] : slot_data_reg[gi];
        end
    endgenerate

    always_comb begin
        pick_valid = |cand_full;
        pick_idx   = '0;
        // Scan downward so the lowest candidate position wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (cand_full[k]) begin
                pick_idx = cand_idx[k];
            end
        end
    end

    always_comb begin
        state_next        = state_reg;
        ptr_next          = ptr_reg;
        grant_next        = grant_reg;
        utx_data_next     = utx_data_reg;
        data_ready_next   = 1'b0;
        bit_duration_next = bit_duration_reg;
        stopbits_next     = stopbits_reg;
        req_sent_next     = '0;
        first_wait_next   = 1'b0;
        pend_clear        = 1'b0;
        slot_full_next    = slot_full_reg | (req_valid & ~slot_full_reg);

        case (state_reg)
            S_IDLE: begin
                if (cfg_pending_reg) begin
                    // Applying config takes this idle cycle; no grant.
                    bit_duration_next = pend_bit_duration_reg;
                    stopbits_next     = pend_stopbits_reg;
                    pend_clear        = 1'b1;
                end else if (pick_valid) begin
                    grant_next      = pick_idx;
                    ptr_next        = pick_idx;
                    utx_data_next   = slot_data_reg[pick_idx];
                    data_ready_next = 1'b1;
                    state_next      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Free the slot now so the producer can refill mid-frame.
                slot_full_next[grant_reg] = 1'b0;
                first_wait_next           = 1'b1;
                state_next                = S_WAIT;
            end
            S_WAIT: begin
                // tx_complete seen in the first wait cycle belongs to the
                // previous frame and is ignored.
                if (!first_wait_reg && utx_tx_complete) begin
                    req_sent_next[grant_reg] = 1'b1;
                    state_next               = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        busy_next = (state_next != S_IDLE);
        // A new write wins over the clear so the latest value is never lost.
        cfg_pending_next = cfg_we ? 1'b1 : (pend_clear ? 1'b0 : cfg_pending_reg);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg             <= S_IDLE;
            slot_full_reg         <= '0;
            slot_data_reg         <= '0;
            ptr_reg               <= IW'(NREQ - 1);
            grant_reg             <= '0;
            utx_data_reg          <= '0;
            data_ready_reg        <= 1'b0;
            bit_duration_reg      <= DEFAULT_BIT_DURATION;
            stopbits_reg          <= DEFAULT_STOPBITS;
            cfg_pending_reg       <= 1'b0;
            pend_bit_duration_reg <= DEFAULT_BIT_DURATION;
            pend_stopbits_reg     <= DEFAULT_STOPBITS;
            req_sent_reg          <= '0;
            busy_reg              <= 1'b0;
            first_wait_reg        <= 1'b0;
        end else begin
            state_reg        <= state_next;
            slot_full_reg    <= slot_full_next;
            slot_data_reg    <= slot_data_next;
            ptr_reg          <= ptr_next;
            grant_reg        <= grant_next;
            utx_data_reg     <= utx_data_next;
            data_ready_reg   <= data_ready_next;
            bit_duration_reg <= bit_duration_next;
            stopbits_reg     <= stopbits_next;
            cfg_pending_reg  <= cfg_pending_next;
            if (cfg_we) begin
                pend_bit_duration_reg <= cfg_bit_duration;
                pend_stopbits_reg     <= cfg_stopbits;
            end
            req_sent_reg     <= req_sent_next;
            busy_reg         <= busy_next;
            first_wait_reg   <= first_wait_next;
        end
    end

    assign req_ready        = ~slot_full_reg;
    assign req_sent         = req_sent_reg;
    assign utx_data         = utx_data_reg;
    assign utx_data_ready   = data_ready_reg;
    assign utx_bit_duration = bit_duration_reg;
    assign utx_stopbits     = stopbits_reg;
    assign busy             = busy_reg;
    assign grant_id         = grant_reg;
endmodule

// File: tb/tb_uart_tx_sched.sv
// Testbench for uart_tx_sched. A responder stands in for uart_tx; every
// issued frame is compared against a scoreboard of expected grants.
module tb_uart_tx_sched;
    localparam int NREQ      = 4;
    localparam int FRAME_CYC = 30;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   req_sent;
    logic              cfg_we;
    logic [15:0]       cfg_bit_duration;
    logic [1:0]        cfg_stopbits;
    logic [7:0]        utx_data;
    logic              utx_data_ready;
    logic [15:0]       utx_bit_duration;
    logic [1:0]        utx_stopbits;
    logic              utx_tx_complete;
    logic              busy;
    logic [1:0]        grant_id;

    uart_tx_sched #(.NREQ(NREQ)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .req_sent         (req_sent),
        .cfg_we           (cfg_we),
        .cfg_bit_duration (cfg_bit_duration),
        .cfg_stopbits     (cfg_stopbits),
        .utx_data         (utx_data),
        .utx_data_ready   (utx_data_ready),
        .utx_bit_duration (utx_bit_duration),
        .utx_stopbits     (utx_stopbits),
        .utx_tx_complete  (utx_tx_complete),
        .busy             (busy),
        .grant_id         (grant_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  id;
        logic [7:0]  data;
        logic [15:0] bd;
        logic [1:0]  sb;
        int          gap;   // cycles from req_sent to next strobe, -1 = unchecked
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   frames_expected = 0;
    int   frames_done = 0;
    int   last_sent_cyc = 0;
    int   cyc = 0;
    bit   rsp_abort = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_frame(input logic [1:0] id, input logic [7:0] data,
                                input logic [15:0] bd, input logic [1:0] sb, input int gap);
        exp_t e;
        e.id = id; e.data = data; e.bd = bd; e.sb = sb; e.gap = gap;
        sb_q.push_back(e);
        frames_expected++;
    endtask

    task automatic wait_done();
        int n = 0;
        while (frames_done < frames_expected && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("frames_done", frames_done, frames_expected);
        check("scoreboard_empty", sb_q.size(), 0);
    endtask

    task automatic wait_issue();
        int n = 0;
        while (!utx_data_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("issue_seen", utx_data_ready, 1);
    endtask

    task automatic wait_slot_free(input int id);
        int n = 0;
        while (!req_ready[id] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("slot_freed", req_ready[id], 1);
    endtask

    // Scoreboard side: every start strobe must match the next expected frame.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && utx_data_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_issue", 1, 0);
            end else begin
                e = sb_q.pop_front();
                $display("frame: id=%0d data=%02h bd=%0d sb=%0d (expect id=%0d data=%02h bd=%0d sb=%0d)",
                         grant_id, utx_data, utx_bit_duration, utx_stopbits, e.id, e.data, e.bd, e.sb);
                check("grant_id", grant_id, e.id);
                check("utx_data", utx_data, e.data);
                check("bit_duration", utx_bit_duration, e.bd);
                check("stopbits", utx_stopbits, e.sb);
                if (e.gap >= 0) check("grant_gap", cyc - last_sent_cyc, e.gap);
            end
        end
    end

    // uart_tx stand-in: a stale tx_complete in the first wait cycle, then the
    // real completion after FRAME_CYC cycles unless a reset aborts the frame.
    initial begin : responder
        logic [15:0] bd0;
        logic [1:0]  sb0;
        logic [1:0]  id0;
        bit          aborted;
        utx_tx_complete = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && utx_data_ready) begin
                bd0 = utx_bit_duration; sb0 = utx_stopbits; id0 = grant_id; aborted = 1'b0;
                @(negedge clk);
                utx_tx_complete = 1'b1;
                @(negedge clk);
                utx_tx_complete = 1'b0;
                check("stale_complete_busy", busy, 1);
                check("stale_complete_sent", req_sent, 0);
                for (int k = 0; k < FRAME_CYC; k++) begin
                    @(negedge clk);
                    if (rsp_abort) begin
                        aborted = 1'b1;
                        break;
                    end
                end
                if (!aborted) begin
                    check("cfg_stable_bd", utx_bit_duration, bd0);
                    check("cfg_stable_sb", utx_stopbits, sb0);
                    utx_tx_complete = 1'b1;
                    @(negedge clk);
                    utx_tx_complete = 1'b0;
                    check("req_sent", req_sent, 32'(1 << id0));
                    check("busy_after_frame", busy, 0);
                    last_sent_cyc = cyc;
                end
                frames_done++;
            end
        end
    end

    initial begin : stimulus
        rst_n = 1'b0; req_valid = '0; req_data = '0;
        cfg_we = 1'b0; cfg_bit_duration = '0; cfg_stopbits = '0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 4'hF);
        check("rst_busy", busy, 0);
        check("rst_data_ready", utx_data_ready, 0);
        check("rst_utx_data", utx_data, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_req_sent", req_sent, 0);
        check("rst_bit_duration", utx_bit_duration, 16'd433);
        check("rst_stopbits", utx_stopbits, 2'b01);
        rst_n = 1'b1;
        @(negedge clk);

        // Round-robin: all four full at once, pointer starts at 3.
        expect_frame(0, 8'hA0, 433, 1, -1);
        expect_frame(1, 8'hA1, 433, 1, 1);
        expect_frame(2, 8'hA2, 433, 1, 1);
        expect_frame(3, 8'hA3, 433, 1, 1);
        req_valid = 4'hF; req_data = 32'hA3A2A1A0;
        @(negedge clk);
        req_valid = '0;
        wait_done();

        // Single byte with grant latency.
        expect_frame(2, 8'h55, 433, 1, -1);
        req_valid[2] = 1'b1; req_data[23:16] = 8'h55;
        @(negedge clk);
        req_valid = '0;
        check("latency_not_yet", utx_data_ready, 0);
        check("slot2_full", req_ready[2], 0);
        @(negedge clk);
        check("latency_strobe", utx_data_ready, 1);
        wait_done();

        // Refill during frame: order 0,1,0.
        expect_frame(0, 8'h10, 433, 1, -1);
        expect_frame(1, 8'h11, 433, 1, 1);
        expect_frame(0, 8'h12, 433, 1, 1);
        req_valid = 4'b0011; req_data[15:0] = 16'h1110;
        @(negedge clk);
        req_valid = '0;
        wait_slot_free(0);
        req_valid[0] = 1'b1; req_data[7:0] = 8'h12;
        @(negedge clk);
        req_valid = '0;
        wait_done();

        // Deferred config written mid-frame.
        expect_frame(3, 8'h33, 433, 1, -1);
        expect_frame(1, 8'h31, 9, 3, 2);
        req_valid[3] = 1'b1; req_data[31:24] = 8'h33;
        @(negedge clk);
        req_valid = '0;
        wait_issue();
        repeat (3) @(negedge clk);
        cfg_we = 1'b1; cfg_bit_duration = 16'd9; cfg_stopbits = 2'b11;
        req_valid[1] = 1'b1; req_data[15:8] = 8'h31;
        @(negedge clk);
        cfg_we = 1'b0; req_valid = '0;
        check("cfg_held_while_busy", utx_bit_duration, 16'd433);
        wait_done();

        // Two config writes before the next idle: last one wins.
        expect_frame(2, 8'h42, 9, 3, -1);
        expect_frame(0, 8'h40, 19, 2, 2);
        req_valid[2] = 1'b1; req_data[23:16] = 8'h42;
        @(negedge clk);
        req_valid = '0;
        wait_issue();
        repeat (3) @(negedge clk);
        cfg_we = 1'b1; cfg_bit_duration = 16'd9; cfg_stopbits = 2'b00;
        @(negedge clk);
        cfg_bit_duration = 16'd19; cfg_stopbits = 2'b10;
        req_valid[0] = 1'b1; req_data[7:0] = 8'h40;
        @(negedge clk);
        cfg_we = 1'b0; req_valid = '0;
        wait_done();

        // Asynchronous reset in the middle of a frame.
        expect_frame(1, 8'h51, 19, 2, -1);
        req_valid[1] = 1'b1; req_data[15:8] = 8'h51;
        @(negedge clk);
        req_valid = '0;
        wait_issue();
        repeat (5) @(negedge clk);
        rsp_abort = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("async_busy", busy, 0);
        check("async_req_ready", req_ready, 4'hF);
        check("async_data_ready", utx_data_ready, 0);
        check("async_utx_data", utx_data, 0);
        check("async_grant_id", grant_id, 0);
        check("async_bit_duration", utx_bit_duration, 16'd433);
        check("async_stopbits", utx_stopbits, 2'b01);
        wait_done();
        rsp_abort = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // After release the pointer is back at 3, so 0 goes before 2.
        expect_frame(0, 8'h60, 433, 1, -1);
        expect_frame(2, 8'h62, 433, 1, 1);
        req_valid = 4'b0101; req_data = 32'h00620060;
        @(negedge clk);
        req_valid = '0;
        wait_done();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
